// File: rtl/switch_scan_ctrl.sv
// Switch bank scanner: synchronises the raw pins, samples them on a prescaled tick,
// debounces over STABLE_COUNT ticks, and exposes state, sticky edges, mask and control registers.
module switch_scan_ctrl #(
   parameter int WIDTH        = 32,
   parameter int PRESCALE     = 50000,
   parameter int STABLE_COUNT = 4
) (
   input  logic             iClk,
   input  logic             iReset,
   input  logic [WIDTH-1:0] iSwitches_data,
   input  logic             iChip_select_n,
   input  logic             iRead_n,
   input  logic             iWrite_n,
   input  logic [1:0]       iAddress,
   input  logic [31:0]      iWrite_data,
   output logic [31:0]      oRead_data,
   output logic             oIrq,
   output logic [1:0]       oScanState
);

   localparam int PW = $clog2(PRESCALE);
   localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT - 1);

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_SAMPLE = 2'd1,
      S_COMMIT = 2'd2
   } scanState_t;

   scanState_t       state;
   scanState_t       nextState;
   logic [WIDTH-1:0] syncMeta;
   logic [WIDTH-1:0] syncOut;
   logic [WIDTH-1:0] lastSample;
   logic [WIDTH-1:0] stateReg;
   logic [WIDTH-1:0] edgesReg;
   logic [WIDTH-1:0] maskReg;
   logic [WIDTH-1:0] commitSet;
   logic [WIDTH-1:0] edgesClr;
   logic [PW-1:0]    preCnt;
   logic [CW-1:0]    stableCnt;
   logic [31:0]      readMux;
   logic             enable;
   logic             tick;
   logic             rdEn;
   logic             wrEn;
   logic             restart;
   logic             doCapture;
   logic             doCount;
   logic             doCommit;
   logic             irqReg;
   logic [31:0]      readReg;

   // Bus strobes are single-cycle qualified by select; there is no wait state.
   // A write always wins over a simultaneous read, which then leaves oRead_data unchanged.
   assign wrEn    = !iChip_select_n && !iWrite_n;
   assign rdEn    = !iChip_select_n && !iRead_n && !wrEn;
   assign restart = wrEn && (iAddress == 2'd3) && iWrite_data[1];
   assign tick    = enable && (preCnt == PRE_MAX);

   always_ff @(posedge iClk) begin
      if (iReset) begin
         syncMeta <= '0;
         syncOut  <= '0;
      end else begin
         syncMeta <= iSwitches_data;
         syncOut  <= syncMeta;
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset || restart || !enable || tick) begin
         preCnt <= '0;
      end else begin
         preCnt <= preCnt + 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state <= S_WAIT;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         S_WAIT:   if (tick) nextState = S_SAMPLE;
         S_SAMPLE: begin
            if (syncOut != lastSample)    nextState = S_WAIT;
            else if (stableCnt < CNT_MAX) nextState = S_WAIT;
            else                          nextState = S_COMMIT;
         end
         S_COMMIT: nextState = S_WAIT;
         default:  nextState = S_WAIT;
      endcase
      if (restart) nextState = S_WAIT;
   end

   always_comb begin
      doCapture = 1'b0;
      doCount   = 1'b0;
      doCommit  = 1'b0;
      case (state)
         S_SAMPLE: begin
            if (syncOut != lastSample)    doCapture = 1'b1;
            else if (stableCnt < CNT_MAX) doCount   = 1'b1;
         end
         S_COMMIT: doCommit = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         lastSample <= '0;
         stableCnt  <= '0;
      end else if (restart || doCapture) begin
         lastSample <= syncOut;
         stableCnt  <= '0;
      end else if (doCount) begin
         stableCnt <= stableCnt + 1'b1;
      end
   end

   // A commit setting an edge bit beats a W1C of the same bit in the same cycle.
   assign commitSet = doCommit ? (lastSample ^ stateReg) : '0;
   assign edgesClr  = (wrEn && (iAddress == 2'd1)) ? iWrite_data[WIDTH-1:0] : '0;

   always_ff @(posedge iClk) begin
      if (iReset) begin
         stateReg <= '0;
         edgesReg <= '0;
         maskReg  <= '0;
         enable   <= 1'b1;
         irqReg   <= 1'b0;
      end else begin
         if (doCommit) stateReg <= lastSample;
         edgesReg <= (edgesReg & ~edgesClr) | commitSet;
         if (wrEn && (iAddress == 2'd2)) maskReg <= iWrite_data[WIDTH-1:0];
         if (wrEn && (iAddress == 2'd3)) enable <= iWrite_data[0];
         irqReg <= |(edgesReg & maskReg);
      end
   end

   always_comb begin
      readMux = '0;
      case (iAddress)
         2'd0:    readMux = 32'(stateReg);
         2'd1:    readMux = 32'(edgesReg);
         2'd2:    readMux = 32'(maskReg);
         default: readMux = {31'b0, enable};
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         readReg <= '0;
      end else if (rdEn) begin
         readReg <= readMux;
      end
   end

   assign oRead_data = readReg;
   assign oIrq       = irqReg;
   assign oScanState = state;

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Directed bench for switch_scan_ctrl with a short prescaler so debounce timing
// can be followed tick by tick through the exposed scan state.
module tb_switch_scan_ctrl;

   localparam int W  = 32;
   localparam int PS = 4;
   localparam int SC = 2;
   localparam logic [1:0] ST_WAIT   = 2'd0;
   localparam logic [1:0] ST_SAMPLE = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   logic          iClk = 1'b0;
   logic          iReset = 1'b1;
   logic [W-1:0]  iSwitches_data = '0;
   logic          iChip_select_n = 1'b1;
   logic          iRead_n = 1'b1;
   logic          iWrite_n = 1'b1;
   logic [1:0]    iAddress = 2'd0;
   logic [31:0]   iWrite_data = '0;
   logic [31:0]   oRead_data;
   logic          oIrq;
   logic [1:0]    oScanState;

   int errCount = 0;
   int checkCount = 0;

   switch_scan_ctrl #(.WIDTH(W), .PRESCALE(PS), .STABLE_COUNT(SC)) dut (
      .iClk           (iClk),
      .iReset         (iReset),
      .iSwitches_data (iSwitches_data),
      .iChip_select_n (iChip_select_n),
      .iRead_n        (iRead_n),
      .iWrite_n       (iWrite_n),
      .iAddress       (iAddress),
      .iWrite_data    (iWrite_data),
      .oRead_data     (oRead_data),
      .oIrq           (oIrq),
      .oScanState     (oScanState)
   );

   always #5 iClk = ~iClk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
      iChip_select_n = 1'b0;
      iWrite_n       = 1'b0;
      iAddress       = addr;
      iWrite_data    = data;
      @(negedge iClk);
      iChip_select_n = 1'b1;
      iWrite_n       = 1'b1;
   endtask

   task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
      iChip_select_n = 1'b0;
      iRead_n        = 1'b0;
      iAddress       = addr;
      @(negedge iClk);
      data           = oRead_data;
      iChip_select_n = 1'b1;
      iRead_n        = 1'b1;
   endtask

   task automatic readCheck(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      busRead(addr, d);
      checkVal(tag, d, exp);
   endtask

   // Reads STATE every cycle until it matches or the cycle budget runs out.
   task automatic pollState(input string tag, input logic [31:0] exp, input int limit);
      logic [31:0] d;
      int n;
      n = 0;
      d = ~exp;
      while (d !== exp && n < limit) begin
         busRead(2'd0, d);
         n++;
      end
      checkVal(tag, d, exp);
   endtask

   task automatic waitState(input string tag, input logic [1:0] s);
      int n;
      n = 0;
      @(negedge iClk);
      while (oScanState !== s && n < 50) begin
         @(negedge iClk);
         n++;
      end
      checkVal(tag, {30'b0, oScanState}, {30'b0, s});
   endtask

   logic [31:0] bouncePins [3];
   logic [31:0] settleExp  [3];

   initial begin
      bouncePins = '{32'h1, 32'h0, 32'h1};
      settleExp  = '{32'h0, 32'h0, 32'h1};

      // Reset
      repeat (3) @(negedge iClk);
      iReset = 1'b0;
      checkVal("irq_reset", {31'b0, oIrq}, 32'h0);
      checkVal("rdata_reset", oRead_data, 32'h0);
      readCheck("state_reset", 2'd0, 32'h0);
      readCheck("ctrl_reset", 2'd3, 32'h1);
      readCheck("edges_reset", 2'd1, 32'h0);
      readCheck("mask_reset", 2'd2, 32'h0);

      // Clean change to 0xA5, interrupt, W1C clear
      busWrite(2'd2, 32'hFF);
      readCheck("mask_rw", 2'd2, 32'hFF);
      iSwitches_data = 32'hA5;
      pollState("commit_a5", 32'hA5, 18);
      checkVal("irq_set", {31'b0, oIrq}, 32'h1);
      readCheck("edges_a5", 2'd1, 32'hA5);
      busWrite(2'd1, 32'hA5);
      checkVal("irq_hold", {31'b0, oIrq}, 32'h1);
      @(negedge iClk);
      checkVal("irq_clear", {31'b0, oIrq}, 32'h0);
      readCheck("edges_clr", 2'd1, 32'h0);

      // Back to zero, clear edges
      iSwitches_data = 32'h0;
      pollState("commit_zero", 32'h0, 18);
      busWrite(2'd1, 32'hFF);
      readCheck("edges_clr2", 2'd1, 32'h0);

      // Bounce: change pins at three consecutive samples, then hold at 0x1
      for (int i = 0; i < 3; i++) begin
         waitState("bounce_sample", ST_SAMPLE);
         iSwitches_data = bouncePins[i];
         repeat (2) @(negedge iClk);
         readCheck("bounce_hold", 2'd0, 32'h0);
      end
      for (int j = 0; j < 3; j++) begin
         waitState("settle_sample", ST_SAMPLE);
         repeat (2) @(negedge iClk);
         readCheck("settle_state", 2'd0, settleExp[j]);
      end

      // W1C coinciding with a commit that sets bit0
      iSwitches_data = 32'h3;
      pollState("commit_3", 32'h3, 18);
      readCheck("edges_pre", 2'd1, 32'h3);
      waitState("sw_sample0", ST_SAMPLE);
      iSwitches_data = 32'h2;
      for (int k = 0; k < 3; k++) waitState("sw_sample", ST_SAMPLE);
      waitState("sw_commit", ST_COMMIT);
      busWrite(2'd1, 32'h3);
      readCheck("edges_setwins", 2'd1, 32'h1);
      readCheck("state_2", 2'd0, 32'h2);

      // Disable scanning, then re-enable
      busWrite(2'd3, 32'h0);
      readCheck("ctrl_dis", 2'd3, 32'h0);
      iSwitches_data = 32'hF;
      repeat (10 * PS) @(negedge iClk);
      readCheck("state_frozen", 2'd0, 32'h2);
      checkVal("fsm_idle", {30'b0, oScanState}, {30'b0, ST_WAIT});
      busWrite(2'd3, 32'h1);
      pollState("commit_f", 32'hF, 20);
      busWrite(2'd3, 32'h3);
      readCheck("ctrl_restart", 2'd3, 32'h1);
      readCheck("state_keep", 2'd0, 32'hF);

      // Reset during a committing cycle
      busWrite(2'd2, 32'hFFFF_FFFF);
      readCheck("mask_all", 2'd2, 32'hFFFF_FFFF);
      readCheck("edges_d", 2'd1, 32'hD);
      checkVal("irq_pre", {31'b0, oIrq}, 32'h1);
      waitState("rst_sample0", ST_SAMPLE);
      iSwitches_data = 32'h0;
      for (int k = 0; k < 3; k++) waitState("rst_sample", ST_SAMPLE);
      waitState("rst_commit", ST_COMMIT);
      iReset = 1'b1;
      @(negedge iClk);
      iReset = 1'b0;
      checkVal("irq_after_rst", {31'b0, oIrq}, 32'h0);
      checkVal("rdata_after_rst", oRead_data, 32'h0);
      checkVal("fsm_after_rst", {30'b0, oScanState}, {30'b0, ST_WAIT});
      readCheck("state_after_rst", 2'd0, 32'h0);
      readCheck("edges_after_rst", 2'd1, 32'h0);
      readCheck("mask_after_rst", 2'd2, 32'h0);
      readCheck("ctrl_after_rst", 2'd3, 32'h1);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
